alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles alu_a/alu_b/alu_op are held before result capture; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_a, req_b  input  32 each  operands.
REQ-007 req_op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; 011/100/101 illegal.
REQ-008 alu_a, alu_b  output  32 each  operands driven to the ALU.
REQ-009 alu_op  output  3  op driven to the ALU; SLT drives 110.
REQ-010 alu_result  input  32  ALU result.
REQ-011 alu_cout, alu_zero, alu_set  input  1 each  ALU carry-out, a==b, sign of a-b.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_result  output  32  captured result.
REQ-015 rsp_flags  output  4  {overflow, set, zero, cout}.
REQ-016 rsp_err  output  1  request had illegal op.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 FSM states IDLE, DRIVE, RESPOND; req_ready is high only in IDLE.
REQ-019 Acceptance is req_valid && req_ready at a rising edge; operands and op are registered at that edge.
REQ-020 Legal op accepted: go to DRIVE, load counter with SETTLE_CYCLES-1, register alu_a/alu_b/alu_op.
REQ-021 alu_a, alu_b and alu_op are held constant for the entire DRIVE and RESPOND states; they are not cleared on return to IDLE.
REQ-022 DRIVE: counter decrements each cycle; at the edge where counter is 0, capture result/flags and go to RESPOND; rsp_valid rises exactly SETTLE_CYCLES cycles after the acceptance edge.
REQ-023 Captured rsp_result: alu_result for AND/OR/ADD/SUB; {31'b0, alu_set} for SLT.
REQ-024 Captured cout = alu_cout; zero = alu_zero; set = alu_set, for every legal op.
REQ-025 Overflow is computed by the controller from the registered operands, not taken from the ALU: ADD = (a31==b31)&&(r31!=a31); SUB/SLT = (a31!=b31)&&(r31!=a31); AND/OR = 0. Here r31 is alu_result[31].
REQ-026 Illegal op accepted: skip DRIVE and go straight to RESPOND, so rsp_valid rises 1 cycle after acceptance. Response is rsp_result=0, rsp_flags=0, rsp_err=1. alu_* outputs are unchanged.
REQ-027 RESPOND: rsp_valid high and rsp_* stable until rsp_valid && rsp_ready at an edge; then go to IDLE. No new request is accepted on that same edge.
REQ-028 rsp_err is 0 for every legal-op response.
REQ-029 Throughput for back-to-back legal requests with rsp_ready held high: one response every SETTLE_CYCLES+2 cycles.
REQ-030 req_* changes while the controller is not in IDLE are ignored.

Reset
REQ-031 Reset takes effect at the next rising edge and overrides every other event, including a handshake on the same edge.
REQ-032 Reset values: state=IDLE, counter=0, alu_a=0, alu_b=0, alu_op=000, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, busy=0.
REQ-033 req_ready is high in the cycle after reset is released.
REQ-034 Reset asserted in DRIVE or RESPOND discards the in-flight operation; no response is ever produced for it.

Structure
REQ-035 Shared package alu_pkg holds: op encodings, FSM state enumeration, flag bit indices (OVF=3, SET=2, ZERO=1, COUT=0), and the illegal-op decode function.
REQ-036 One sub-module, alu_ovf_chk, is combinational and computes the overflow of REQ-025 from a31, b31, r31 and op; the ALU itself is external to this block.

Verification
REQ-037 ADD a=-2147483600, b=-200, SETTLE_CYCLES=4, with a behavioural ALU model -> rsp_valid 4 cycles after accept; rsp_result=2147483496; overflow=1; cout=1.
REQ-038 SUB a=5, b=5 -> rsp_result=0, zero=1, set=0, overflow=0; then SLT a=-3, b=2 -> rsp_result=1, set=1.
REQ-039 req_op=101 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0, alu_op keeps its previous value.
REQ-040 rsp_ready held low for 10 cycles in RESPOND -> rsp_* stable, req_ready=0, alu_* constant; release -> IDLE next cycle.
REQ-041 Reset pulsed during DRIVE of an AND request -> all outputs at reset values, no rsp_valid; the next OR request completes normally.
REQ-042 SETTLE_CYCLES=1, back-to-back requests with rsp_ready held high -> one response every 3 cycles; verify each result against the model.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM states, flag bit positions and illegal-op decode shared by the ALU issue controller.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam int F_OVF  = 3;
  localparam int F_SET  = 2;
  localparam int F_ZERO = 1;
  localparam int F_COUT = 0;
  typedef enum logic [1:0] {IDLE, DRIVE, RESPOND} state_t;
  function automatic logic op_illegal(input logic [2:0] op);
    return op == 3'b011 || op == 3'b100 || op == 3'b101;
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, response and external-ALU signals of the issue controller.
interface alu_issue_ctrl_if;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_op;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_cout, alu_zero, alu_set;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;
  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, alu_cout, alu_zero, alu_set, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, alu_cout, alu_zero, alu_set, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags, rsp_err, busy
  );
endinterface

// File: rtl/alu_ovf_chk.sv
// alu_ovf_chk: signed overflow from operand and result sign bits for the requested op.
module alu_ovf_chk
  import alu_pkg::*;
(
  input  logic       a31,
  input  logic       b31,
  input  logic       r31,
  input  logic [2:0] op,
  output logic       ovf
);
  assign ovf = op == OP_ADD ? (a31 == b31) && (r31 != a31) :
               (op == OP_SUB || op == OP_SLT) ? (a31 != b31) && (r31 != a31) : 1'b0;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one op to an external ALU, holds operands SETTLE_CYCLES cycles, then returns result and flags.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input logic             clk,
  input logic             reset,
  alu_issue_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic [3:0]  cnt;
  logic [2:0]  op;
  logic [31:0] alu_a, alu_b, rsp_result;
  logic [2:0]  alu_op;
  logic [3:0]  rsp_flags;
  logic        rsp_err, ovf, acc, ill;
  assign acc = bus.req_valid && state == IDLE;
  assign ill = op_illegal(bus.req_op);
  alu_ovf_chk u_ovf (.a31(alu_a[31]), .b31(alu_b[31]), .r31(bus.alu_result[31]), .op(op), .ovf(ovf));
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (acc ? (ill ? RESPOND : DRIVE) : IDLE) :
               state == DRIVE ? (cnt == 4'd0 ? RESPOND : DRIVE) :
               (bus.rsp_ready ? IDLE : RESPOND);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 4'd0;
      op         <= OP_AND;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_op     <= OP_AND;
      rsp_result <= 32'd0;
      rsp_flags  <= 4'd0;
      rsp_err    <= 1'b0;
    end else begin
      if (acc && !ill) begin
        cnt    <= 4'(SETTLE_CYCLES - 1);
        op     <= bus.req_op;
        alu_a  <= bus.req_a;
        alu_b  <= bus.req_b;
        alu_op <= bus.req_op == OP_SLT ? OP_SUB : bus.req_op;
      end
      if (acc && ill) begin
        rsp_result <= 32'd0;
        rsp_flags  <= 4'd0;
        rsp_err    <= 1'b1;
      end
      if (state == DRIVE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == DRIVE && cnt == 4'd0) begin
        rsp_result <= op == OP_SLT ? {31'd0, bus.alu_set} : bus.alu_result;
        rsp_flags  <= {ovf, bus.alu_set, bus.alu_zero, bus.alu_cout};
        rsp_err    <= 1'b0;
      end
    end
  end
  assign bus.req_ready  = state == IDLE;
  assign bus.busy       = state != IDLE;
  assign bus.rsp_valid  = state == RESPOND;
  assign bus.alu_a      = alu_a;
  assign bus.alu_b      = alu_b;
  assign bus.alu_op     = alu_op;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_flags  = rsp_flags;
  assign bus.rsp_err    = rsp_err;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of the issue controller against a behavioural ALU, SETTLE_CYCLES of 4 and 1.
module tb_alu_issue_ctrl;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  alu_issue_ctrl_if bi ();
  alu_issue_ctrl_if b1 ();
  alu_issue_ctrl #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bi.slave));
  alu_issue_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  always #5 clk = ~clk;
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
    logic [32:0] s;
    logic [31:0] d;
    d = a - b;
    s = o == 3'b010 ? {1'b0, a} + {1'b0, b} :
        o == 3'b110 ? {1'b0, a} + {1'b0, ~b} + 33'd1 :
        {1'b0, o == 3'b000 ? a & b : a | b};
    return {s[32], a == b, d[31], s[31:0]};
  endfunction
  assign {bi.alu_cout, bi.alu_zero, bi.alu_set, bi.alu_result} = alu_model(bi.alu_a, bi.alu_b, bi.alu_op);
  assign {b1.alu_cout, b1.alu_zero, b1.alu_set, b1.alu_result} = alu_model(b1.alu_a, b1.alu_b, b1.alu_op);
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o, output int lat);
    @(negedge clk);
    bi.req_valid = 1'b1;
    bi.req_a = a;
    bi.req_b = b;
    bi.req_op = o;
    @(posedge clk);
    #1;
    bi.req_valid = 1'b0;
    bi.req_a = 32'hDEAD_BEEF;
    bi.req_b = 32'h1234_5678;
    bi.req_op = OP_OR;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bi.rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic release_rsp();
    bi.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bi.rsp_ready = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bi.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %0b want 0", bi.rsp_valid); end
    checks++; if (bi.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", bi.busy); end
    checks++; if ({bi.alu_a, bi.alu_b, bi.alu_op} !== 67'd0) begin fails++; $display("FAIL reset_alu: got %0h/%0h/%0b want 0", bi.alu_a, bi.alu_b, bi.alu_op); end
    checks++; if ({bi.rsp_result, bi.rsp_flags, bi.rsp_err} !== 37'd0) begin fails++; $display("FAIL reset_rsp: got %0h/%0b/%0b want 0", bi.rsp_result, bi.rsp_flags, bi.rsp_err); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bi.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %0b want 1", bi.req_ready); end
  endtask
  task automatic test_add();
    int lat;
    issue(32'h8000_0030, 32'hFFFF_FF38, OP_ADD, lat);
    checks++; if (lat !== 4) begin fails++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++; if (bi.rsp_result !== 32'h7FFF_FF68) begin fails++; $display("FAIL add_result: got %0h want 7fffff68", bi.rsp_result); end
    checks++; if (bi.rsp_flags[F_OVF] !== 1'b1 || bi.rsp_flags[F_COUT] !== 1'b1) begin fails++; $display("FAIL add_flags: got %4b want 1xx1", bi.rsp_flags); end
    checks++; if (bi.rsp_err !== 1'b0) begin fails++; $display("FAIL add_err: got %0b want 0", bi.rsp_err); end
    checks++; if (bi.alu_a !== 32'h8000_0030 || bi.alu_op !== OP_ADD) begin fails++; $display("FAIL add_alu_hold: got %0h/%0b want 80000030/010", bi.alu_a, bi.alu_op); end
    release_rsp();
  endtask
  task automatic test_sub_slt();
    int lat;
    issue(32'd5, 32'd5, OP_SUB, lat);
    checks++; if (lat !== 4 || bi.rsp_result !== 32'd0) begin fails++; $display("FAIL sub_result: got lat %0d res %0h want 4/0", lat, bi.rsp_result); end
    checks++; if (bi.rsp_flags !== 4'b0011) begin fails++; $display("FAIL sub_flags: got %4b want 0011", bi.rsp_flags); end
    release_rsp();
    issue(32'hFFFF_FFFD, 32'd2, OP_SLT, lat);
    checks++; if (lat !== 4 || bi.rsp_result !== 32'd1) begin fails++; $display("FAIL slt_result: got lat %0d res %0h want 4/1", lat, bi.rsp_result); end
    checks++; if (bi.rsp_flags !== 4'b0101) begin fails++; $display("FAIL slt_flags: got %4b want 0101", bi.rsp_flags); end
    checks++; if (bi.alu_op !== 3'b110) begin fails++; $display("FAIL slt_alu_op: got %3b want 110", bi.alu_op); end
    release_rsp();
  endtask
  task automatic test_illegal();
    int lat;
    issue(32'h55, 32'hAA, 3'b101, lat);
    checks++; if (lat !== 1) begin fails++; $display("FAIL ill_latency: got %0d want 1", lat); end
    checks++; if (bi.rsp_err !== 1'b1 || bi.rsp_result !== 32'd0 || bi.rsp_flags !== 4'd0) begin fails++; $display("FAIL ill_rsp: got err %0b res %0h flags %4b want 1/0/0000", bi.rsp_err, bi.rsp_result, bi.rsp_flags); end
    checks++; if (bi.alu_op !== 3'b110 || bi.alu_a !== 32'hFFFF_FFFD) begin fails++; $display("FAIL ill_alu_keep: got %3b/%0h want 110/fffffffd", bi.alu_op, bi.alu_a); end
    release_rsp();
    issue(32'h1, 32'h2, 3'b011, lat);
    checks++; if (lat !== 1 || bi.rsp_err !== 1'b1) begin fails++; $display("FAIL ill011: got lat %0d err %0b want 1/1", lat, bi.rsp_err); end
    release_rsp();
  endtask
  task automatic test_stall();
    int lat;
    int bad = 0;
    issue(32'hF0F0_0000, 32'h0000_0F0F, OP_OR, lat);
    checks++; if (lat !== 4 || bi.rsp_result !== 32'hF0F0_0F0F || bi.rsp_flags !== 4'b0100) begin fails++; $display("FAIL or_rsp: got lat %0d res %0h flags %4b want 4/f0f00f0f/0100", lat, bi.rsp_result, bi.rsp_flags); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!bi.rsp_valid || bi.req_ready || bi.rsp_result !== 32'hF0F0_0F0F || bi.rsp_err !== 1'b0 ||
          bi.alu_a !== 32'hF0F0_0000 || bi.alu_b !== 32'h0000_0F0F || bi.alu_op !== OP_OR) bad++;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); end
    bi.rsp_ready = 1'b1;
    bi.req_valid = 1'b1;
    bi.req_op = OP_ADD;
    @(posedge clk);
    #1;
    bi.rsp_ready = 1'b0;
    bi.req_valid = 1'b0;
    checks++; if (bi.req_ready !== 1'b1 || bi.busy !== 1'b0 || bi.rsp_valid !== 1'b0) begin fails++; $display("FAIL stall_release: got ready %0b busy %0b valid %0b want 1/0/0", bi.req_ready, bi.busy, bi.rsp_valid); end
  endtask
  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    @(negedge clk);
    bi.req_valid = 1'b1;
    bi.req_a = 32'hFF00_FF00;
    bi.req_b = 32'h0F0F_0F0F;
    bi.req_op = OP_AND;
    @(posedge clk);
    #1;
    bi.req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (bi.busy !== 1'b0 || bi.rsp_valid !== 1'b0 || bi.req_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_state: got busy %0b valid %0b ready %0b want 0/0/1", bi.busy, bi.rsp_valid, bi.req_ready); end
    checks++; if ({bi.alu_a, bi.alu_b, bi.alu_op, bi.rsp_result, bi.rsp_flags, bi.rsp_err} !== 104'd0) begin fails++; $display("FAIL rst_mid_regs: got %0h/%0h/%0b/%0h want 0", bi.alu_a, bi.alu_b, bi.alu_op, bi.rsp_result); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bi.rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL rst_mid_no_rsp: got %0d valid cycles want 0", seen); end
    issue(32'h0000_00F0, 32'h0000_0F00, OP_OR, lat);
    checks++; if (lat !== 4 || bi.rsp_result !== 32'h0000_0FF0 || bi.rsp_err !== 1'b0) begin fails++; $display("FAIL rst_mid_next: got lat %0d res %0h err %0b want 4/ff0/0", lat, bi.rsp_result, bi.rsp_err); end
    release_rsp();
  endtask
  task automatic test_back_to_back();
    logic [31:0] va [4] = '{32'd1, 32'd3, 32'd3, 32'hFF00_FF00};
    logic [31:0] vb [4] = '{32'd2, 32'd5, 32'd5, 32'h0FF0_0FF0};
    logic [2:0]  vo [4] = '{OP_ADD, OP_SUB, OP_SLT, OP_AND};
    logic [31:0] vr [4] = '{32'd3, 32'hFFFF_FFFE, 32'd1, 32'h0F00_0F00};
    int k = 0;
    int j = 0;
    int last = -1;
    b1.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && j < 4; cyc++) begin
      @(negedge clk);
      if (b1.req_ready && k < 4) begin
        b1.req_valid = 1'b1;
        b1.req_a = va[k];
        b1.req_b = vb[k];
        b1.req_op = vo[k];
        k++;
      end else b1.req_valid = 1'b0;
      @(posedge clk);
      #1;
      if (b1.rsp_valid) begin
        checks++; if (b1.rsp_result !== vr[j] || b1.rsp_err !== 1'b0) begin fails++; $display("FAIL b2b_result%0d: got %0h err %0b want %0h/0", j, b1.rsp_result, b1.rsp_err, vr[j]); end
        if (last >= 0) begin
          checks++; if (cyc - last !== 3) begin fails++; $display("FAIL b2b_spacing%0d: got %0d want 3", j, cyc - last); end
        end
        last = cyc;
        j++;
      end
    end
    b1.req_valid = 1'b0;
    checks++; if (j !== 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", j); end
  endtask
  initial begin
    bi.req_valid = 1'b0; bi.req_a = '0; bi.req_b = '0; bi.req_op = '0; bi.rsp_ready = 1'b0;
    b1.req_valid = 1'b0; b1.req_a = '0; b1.req_b = '0; b1.req_op = '0; b1.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_slt();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
